vga_plot_arbiter: RTL and testbench

Round-robin arbiter that shares the single `vga_adapter` pixel-write port (x, y, colour, plot) among several pixel producers: the game renderer, the dino sprite renderer and the score/menu overlay. Producers present pixels with a req/gnt handshake and may lock the port for bursts, such as a full-frame sweep. A burst cap keeps a locked producer from starving the others. The block sits between the renderers in `GameImplementation` and the VGA adapter, and it owns every plot issued to the frame buffer.

---
 rtl/vga_plot_arbiter_pkg.sv | 22 ++
 rtl/vga_plot_arbiter_if.sv | 35 +++
 rtl/vga_plot_arbiter_rr_pick.sv | 33 +++
 rtl/vga_plot_arbiter.sv | 131 +++++++++++++
 tb/tb_vga_plot_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_plot_arbiter_pkg.sv
// Shared constants for the VGA plot arbiter: pixel widths, background colour,
// arbiter state encodings and the default burst cap.
package vga_plot_arbiter_pkg;

  localparam int unsigned UBYTE         = 8;
  localparam int unsigned COL_W         = 3;
  localparam int unsigned MAX_BURST_DEF = 255;

  typedef logic [UBYTE-1:0] ubyte_t;
  typedef logic [COL_W-1:0] colour_t;

  localparam colour_t COL_BG = 3'd0;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_OWN  = 1'b1;

  // Width of an index into NREQ requesters; never zero.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Producer-side bus of the plot arbiter: flattened per-requester pixel inputs,
// one-hot grant and the registered pixel write towards the VGA adapter.
interface vga_plot_arbiter_if
  import vga_plot_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XW   = UBYTE,
  parameter int unsigned YW   = UBYTE,
  parameter int unsigned CW   = COL_W
);

  logic                 enable;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      lock;
  logic [NREQ*XW-1:0]   x_in;
  logic [NREQ*YW-1:0]   y_in;
  logic [NREQ*CW-1:0]   color_in;
  logic [NREQ-1:0]      gnt;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic [CW-1:0]        color;
  logic                 plotPixel;
  logic                 busy;

  modport master (
    output enable, req, lock, x_in, y_in, color_in,
    input  gnt, x, y, color, plotPixel, busy
  );

  modport slave (
    input  enable, req, lock, x_in, y_in, color_in,
    output gnt, x, y, color, plotPixel, busy
  );

endinterface

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after `last` (wrapping)
// that is requesting and not excluded.
module vga_plot_arbiter_rr_pick #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  input  logic [NREQ-1:0] excl,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  int unsigned j;
  logic [IW-1:0] jj;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j = 32'(last) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (!valid && req[jj] && !excl[jj]) begin
        valid = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the single VGA adapter plot port; locked producers keep
// the port for bursts capped at MAX_BURST beats.
module vga_plot_arbiter
  import vga_plot_arbiter_pkg::*;
#(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned XW        = UBYTE,
  parameter int unsigned YW        = UBYTE,
  parameter int unsigned CW        = COL_W,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input logic              clk,
  input logic              resetn,
  vga_plot_arbiter_if.slave bus
);

  localparam int unsigned   IW       = idx_w(NREQ);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  logic [0:0]      state_q, state_d;
  logic [IW-1:0]   own_q, own_d;
  logic [IW-1:0]   last_q, last_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [8:0]      cnt_inc;
  logic [NREQ-1:0] gnt;
  logic            beat;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   pick_last;
  logic [NREQ-1:0] pick_excl;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [CW-1:0]   color_q;
  logic            plot_q;

  always_comb begin
    gnt = '0;
    if (state_q == ARB_OWN) gnt[own_q] = bus.req[own_q] & bus.enable;
  end

  assign beat = |gnt;

  // While owning, search from the owner so it ends up at lowest priority; a
  // finished burst also excludes the owner outright.
  assign pick_last = (state_q == ARB_OWN) ? own_q : last_q;

  always_comb begin
    pick_excl = '0;
    if (beat) pick_excl[own_q] = 1'b1;
  end

  vga_plot_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req   (bus.req),
    .last  (pick_last),
    .excl  (pick_excl),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_OWN;
          own_d   = pick_idx;
        end
      end
      ARB_OWN: begin
        if (bus.enable) begin
          if (beat && bus.lock[own_q] && (cnt_inc < 9'(MAX_BURST))) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            // Covers both a finished burst and an owner that dropped req.
            last_d = own_q;
            cnt_d  = '0;
            if (pick_valid) own_d = pick_idx;
            else            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      own_q   <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q     <= '0;
      y_q     <= '0;
      color_q <= CW'(COL_BG);
      plot_q  <= 1'b0;
    end else begin
      plot_q <= beat;
      if (beat) begin
        x_q     <= bus.x_in[own_q*XW +: XW];
        y_q     <= bus.y_in[own_q*YW +: YW];
        color_q <= bus.color_in[own_q*CW +: CW];
      end
    end
  end

  assign bus.gnt       = gnt;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.color     = color_q;
  assign bus.plotPixel = plot_q;
  assign bus.busy      = (state_q == ARB_OWN);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: per-producer pixel queues, a
// behavioural arbitration model and a monitor that checks every plot.
module tb_vga_plot_arbiter;
  import vga_plot_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int XW   = 8;
  localparam int YW   = 8;
  localparam int CW   = 3;
  localparam int MAXB = 200;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
    logic          lk;
  } item_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
  } pix_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  vga_plot_arbiter_if #(.NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW)) bus ();

  vga_plot_arbiter #(
    .NREQ      (NREQ),
    .XW        (XW),
    .YW        (YW),
    .CW        (CW),
    .MAX_BURST (MAXB)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  item_t           pq[NREQ][$];
  pix_t            exp_q[$];
  pix_t            plog[$];
  logic [NREQ-1:0] glog[$];
  bit              plogging = 1'b0;
  bit              glogging = 1'b0;
  int              n_beats = 0;
  int              n_plots = 0;

  // Reference arbitration state: -1 means no owner.
  int m_owner = -1;
  int m_last  = NREQ - 1;
  int m_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr(input int from, input int excl, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (from + k) % NREQ;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
    m_cnt   = 0;
    n_beats -= exp_q.size();
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) pq[i].delete();
  endtask

  // Monitor: every plot must match the oldest outstanding expected pixel.
  always @(negedge clk) begin
    if (resetn && bus.plotPixel) begin
      n_plots++;
      if (plogging) plog.push_back({bus.x, bus.y, bus.color});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d expected none", bus.x, bus.y,
                 bus.color);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        chk("plot_pixel", {bus.x, bus.y, bus.color}, e);
      end
    end
  end

  // One cycle: drive from producer queues at negedge, check gnt/busy, advance model at posedge.
  task automatic step(input bit en, input bit rst_after);
    item_t           head[NREQ];
    logic [NREQ-1:0] r, l, mg, db;
    bus.enable = en;
    for (int i = 0; i < NREQ; i++) begin
      if (pq[i].size() > 0) begin
        head[i] = pq[i][0];
        r[i]    = 1'b1;
      end else begin
        head[i] = '0;
        r[i]    = 1'b0;
      end
      l[i] = head[i].lk;
      bus.x_in[i*XW +: XW]     = head[i].x;
      bus.y_in[i*YW +: YW]     = head[i].y;
      bus.color_in[i*CW +: CW] = head[i].c;
    end
    bus.req  = r;
    bus.lock = l;
    #1;
    mg = '0;
    if (m_owner >= 0 && en && r[m_owner]) mg[m_owner] = 1'b1;
    chk("gnt", bus.gnt, mg);
    chk("busy", bus.busy, (m_owner >= 0));
    db = bus.gnt & r;
    if (glogging && bus.gnt != '0) glog.push_back(bus.gnt);
    @(posedge clk);
    for (int i = 0; i < NREQ; i++) if (db[i]) void'(pq[i].pop_front());
    if (m_owner < 0) begin
      m_owner = rr(m_last, -1, r);
    end else if (en) begin
      int o;
      o = m_owner;
      if (!r[o]) begin
        m_last  = o;
        m_cnt   = 0;
        m_owner = rr(o, -1, r);
      end else begin
        n_beats++;
        exp_q.push_back({head[o].x, head[o].y, head[o].c});
        if (l[o] && m_cnt + 1 < MAXB) begin
          m_cnt++;
        end else begin
          m_last  = o;
          m_cnt   = 0;
          m_owner = rr(o, o, r);
        end
      end
    end
    if (rst_after) begin
      #2;
      resetn = 1'b0;
      #1;
      chk("rst_plot", bus.plotPixel, 1'b0);
      chk("rst_gnt", bus.gnt, '0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_xyc", {bus.x, bus.y, bus.color}, '0);
      model_reset();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    resetn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic int lead_run(input int val);
    int n;
    n = 0;
    while (n < plog.size() && plog[n].y == YW'(val)) n++;
    return n;
  endfunction

  initial begin
    logic [NREQ-1:0] order[6];
    bus.enable   = 1'b0;
    bus.req      = '0;
    bus.lock     = '0;
    bus.x_in     = '0;
    bus.y_in     = '0;
    bus.color_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_gnt", bus.gnt, '0);
    chk("reset_plot", bus.plotPixel, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_xyc", {bus.x, bus.y, bus.color}, '0);
    resetn = 1'b1;

    // Single unlocked pixel from requester 0.
    pq[0].push_back('{x: 8'd5, y: 8'd7, c: 3'd2, lk: 1'b0});
    plogging = 1'b1;
    glogging = 1'b1;
    repeat (4) step(1'b1, 1'b0);
    chk("t1_gnt_count", glog.size(), 1);
    if (glog.size() > 0) chk("t1_first_gnt", glog[0], 3'b001);
    chk("t1_plot_count", plog.size(), 1);
    if (plog.size() > 0) chk("t1_plot_xyc", plog[0], {8'd5, 8'd7, 3'd2});

    // All three requesting, no locks, from reset.
    do_reset();
    glog.delete();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++)
        pq[i].push_back('{x: XW'($urandom), y: YW'(i), c: CW'($urandom), lk: 1'b0});
    repeat (8) step(1'b1, 1'b0);
    order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    chk("t2_gnt_count", glog.size(), 6);
    for (int k = 0; k < 6 && k < glog.size(); k++) chk("t2_gnt_order", glog[k], order[k]);
    glogging = 1'b0;

    // 160-beat locked row from 0 with 2 waiting; enable stalls 3 cycles mid-row.
    plog.delete();
    for (int k = 0; k < 160; k++)
      pq[0].push_back('{x: XW'(k), y: 8'd0, c: CW'(k), lk: (k != 159)});
    pq[2].push_back('{x: 8'd200, y: 8'd2, c: 3'd5, lk: 1'b0});
    for (int c = 0; c < 175; c++) step(!(c >= 50 && c < 53), 1'b0);
    chk("t3_row_len", lead_run(0), 160);
    chk("t3_total_plots", plog.size(), 161);
    if (plog.size() > 160) chk("t3_next_owner", plog[160].y, 2);

    // Burst cap: 0 holds lock beyond MAX_BURST while 1 waits.
    plog.delete();
    for (int k = 0; k < MAXB + 20; k++)
      pq[0].push_back('{x: XW'($urandom), y: 8'd0, c: CW'($urandom), lk: (k != MAXB + 19)});
    pq[1].push_back('{x: 8'd9, y: 8'd1, c: 3'd1, lk: 1'b0});
    repeat (MAXB + 30) step(1'b1, 1'b0);
    chk("t4_capped_run", lead_run(0), MAXB);
    if (plog.size() > MAXB + 1) begin
      chk("t4_waiter", plog[MAXB].y, 1);
      chk("t4_resume", plog[MAXB+1].y, 0);
    end
    chk("t4_total_plots", plog.size(), MAXB + 21);
    plogging = 1'b0;

    // Random traffic with random locks and enable drops.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pq[i].size() == 0 && $urandom_range(3) == 0) begin
          int n;
          n = $urandom_range(1, 4);
          for (int k = 0; k < n; k++)
            pq[i].push_back('{x: XW'($urandom), y: YW'($urandom), c: CW'($urandom),
                              lk: 1'($urandom)});
        end
      end
      step(($urandom_range(9) != 0), 1'b0);
    end
    repeat (20) step(1'b1, 1'b0);

    // Asynchronous reset with a pixel in flight, then requester 0 wins first.
    for (int i = 0; i < NREQ; i++) pq[i].delete();
    repeat (3) step(1'b1, 1'b0);
    for (int k = 0; k < 10; k++)
      pq[0].push_back('{x: XW'(k + 1), y: 8'd3, c: 3'd4, lk: 1'b1});
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    pq[1].push_back('{x: 8'd11, y: 8'd1, c: 3'd3, lk: 1'b0});
    pq[0].push_back('{x: 8'd22, y: 8'd0, c: 3'd6, lk: 1'b0});
    glog.delete();
    glogging = 1'b1;
    repeat (6) step(1'b1, 1'b0);
    glogging = 1'b0;
    chk("t6_gnt_count", glog.size(), 2);
    if (glog.size() > 0) chk("t6_first_gnt", glog[0], 3'b001);

    repeat (3) step(1'b1, 1'b0);
    chk("drain_queue", exp_q.size(), 0);
    chk("plots_eq_beats", n_plots, n_beats);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
